// File: rtl/aes_encrypt_iter_pkg.sv
// Shared types, constants and GF(2^8) helpers for the iterative AES-128 encryptor.
// The S-box is computed as the GF(2^8) inverse followed by the affine transform.
package aes_encrypt_iter_pkg;

  localparam int AES_NR = 10;

  typedef logic [127:0] aes_block_t;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    ROUND = 2'd1,
    DONE  = 2'd2
  } aes_fsm_e;

  localparam logic [0:9][7:0] RCON = {
    8'h01, 8'h02, 8'h04, 8'h08, 8'h10,
    8'h20, 8'h40, 8'h80, 8'h1b, 8'h36
  };

  // Round numbers outside 1..AES_NR return zero; they never reach the key step.
  function automatic logic [7:0] rcon_lookup(input logic [3:0] rnd);
    logic [7:0] val;
    val = 8'h00;
    for (int i = 1; i <= AES_NR; i++) begin
      if (rnd == 4'(i)) val = RCON[i-1];
    end
    return val;
  endfunction

  function automatic logic [7:0] xtime(input logic [7:0] a);
    return {a[6:0], 1'b0} ^ (a[7] ? 8'h1b : 8'h00);
  endfunction

  function automatic logic [7:0] gf_mul(input logic [7:0] a, input logic [7:0] b);
    logic [7:0] acc;
    logic [7:0] aa;
    acc = 8'h00;
    aa  = a;
    for (int i = 0; i < 8; i++) begin
      if (b[i]) acc = acc ^ aa;
      aa = xtime(aa);
    end
    return acc;
  endfunction

  // x^254 is the multiplicative inverse in GF(2^8), and maps 0 to 0 as AES needs.
  function automatic logic [7:0] sbox(input logic [7:0] x);
    logic [7:0] inv;
    logic [7:0] pw;
    inv = 8'h01;
    pw  = x;
    for (int i = 1; i < 8; i++) begin
      pw  = gf_mul(pw, pw);
      inv = gf_mul(inv, pw);
    end
    return inv ^ {inv[6:0], inv[7]} ^ {inv[5:0], inv[7:6]} ^
           {inv[4:0], inv[7:5]} ^ {inv[3:0], inv[7:4]} ^ 8'h63;
  endfunction

endpackage

// File: rtl/aes_encrypt_iter_round.sv
// One combinational AES encryption round: SubBytes, ShiftRows, MixColumns
// (skipped when final_i is set) and AddRoundKey. Byte i sits at bits [127-8i -: 8].
module encrypt_round
  import aes_encrypt_iter_pkg::*;
(
  input  aes_block_t state_i,
  input  aes_block_t round_key_i,
  input  logic       final_i,
  output aes_block_t state_o
);

  logic [7:0] sb [16];
  logic [7:0] sr [16];
  logic [7:0] mc [16];
  logic [7:0] a0, a1, a2, a3;

  // NOTE: every variable in an always_comb gets a value before any branch,
  // otherwise the tool infers a latch to hold the old value.
  always_comb begin
    a0 = '0;
    a1 = '0;
    a2 = '0;
    a3 = '0;
    state_o = '0;
    for (int i = 0; i < 16; i++) begin
      sb[i] = sbox(state_i[127-8*i -: 8]);
    end
    // Column-major state: byte 4c+r is row r, column c; row r rotates left by r.
    for (int c = 0; c < 4; c++) begin
      for (int r = 0; r < 4; r++) begin
        sr[4*c+r] = sb[4*((c+r)%4)+r];
      end
    end
    for (int c = 0; c < 4; c++) begin
      a0 = sr[4*c];
      a1 = sr[4*c+1];
      a2 = sr[4*c+2];
      a3 = sr[4*c+3];
      mc[4*c]   = xtime(a0) ^ xtime(a1) ^ a1 ^ a2 ^ a3;
      mc[4*c+1] = a0 ^ xtime(a1) ^ xtime(a2) ^ a2 ^ a3;
      mc[4*c+2] = a0 ^ a1 ^ xtime(a2) ^ xtime(a3) ^ a3;
      mc[4*c+3] = xtime(a0) ^ a0 ^ a1 ^ a2 ^ xtime(a3);
    end
    for (int i = 0; i < 16; i++) begin
      state_o[127-8*i -: 8] = (final_i ? sr[i] : mc[i]) ^ round_key_i[127-8*i -: 8];
    end
  end

endmodule

// File: rtl/aes_encrypt_iter.sv
// Iterative AES-128 encryptor: one round per clock with on-the-fly key expansion.
// Optional macro AES_LAST_KEY_OUT_EN adds the last_round_key output (round-10 key).
module aes_encrypt_iter
  import aes_encrypt_iter_pkg::*;
(
  input  logic         clk,
  input  logic         rst_n,
  input  logic         in_valid,
  output logic         in_ready,
  input  logic [127:0] plaintext,
  input  logic [127:0] cipher_key,
  output logic         out_valid,
  input  logic         out_ready,
  output logic [127:0] ciphertext,
`ifdef AES_LAST_KEY_OUT_EN
  output logic [127:0] last_round_key,
`endif
  output logic         busy
);

  aes_fsm_e   fsm_q, fsm_d;
  aes_block_t aes_state_q, aes_state_d;
  aes_block_t key_q, key_d;
  logic [3:0] round_q, round_d;

  aes_block_t next_key;
  aes_block_t round_out;
  logic [31:0] rot_word;
  logic [31:0] key_temp;

  // Key schedule step: next four words derived from the current round key.
  always_comb begin
    rot_word = {key_q[23:0], key_q[31:24]};
    key_temp = {sbox(rot_word[31:24]), sbox(rot_word[23:16]),
                sbox(rot_word[15:8]),  sbox(rot_word[7:0])} ^
               {rcon_lookup(round_q), 24'h000000};
    next_key[127:96] = key_q[127:96] ^ key_temp;
    next_key[95:64]  = key_q[95:64]  ^ next_key[127:96];
    next_key[63:32]  = key_q[63:32]  ^ next_key[95:64];
    next_key[31:0]   = key_q[31:0]   ^ next_key[63:32];
  end

  encrypt_round u_round (
    .state_i     (aes_state_q),
    .round_key_i (next_key),
    .final_i     (round_q == 4'(AES_NR)),
    .state_o     (round_out)
  );

  always_comb begin
    fsm_d       = fsm_q;
    aes_state_d = aes_state_q;
    key_d       = key_q;
    round_d     = round_q;
    unique case (fsm_q)
      IDLE: begin
        if (in_valid) begin
          aes_state_d = plaintext ^ cipher_key;
          key_d       = cipher_key;
          round_d     = 4'd1;
          fsm_d       = ROUND;
        end
      end
      ROUND: begin
        aes_state_d = round_out;
        key_d       = next_key;
        // Counter parks at AES_NR so values 11-15 are never entered.
        if (round_q == 4'(AES_NR)) begin
          fsm_d = DONE;
        end else begin
          round_d = round_q + 4'd1;
        end
      end
      DONE: begin
        if (out_ready) fsm_d = IDLE;
      end
      default: fsm_d = IDLE;
    endcase
  end

  // NOTE: sequential state uses non-blocking assignments so every register
  // samples its inputs from before the edge, independent of statement order.
  // The datapath registers are reset too, because ciphertext must read zero in reset.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      fsm_q       <= IDLE;
      aes_state_q <= '0;
      key_q       <= '0;
      round_q     <= 4'd0;
    end else begin
      fsm_q       <= fsm_d;
      aes_state_q <= aes_state_d;
      key_q       <= key_d;
      round_q     <= round_d;
    end
  end

  assign in_ready   = (fsm_q == IDLE);
  assign out_valid  = (fsm_q == DONE);
  assign busy       = (fsm_q != IDLE);
  assign ciphertext = aes_state_q;

`ifdef AES_LAST_KEY_OUT_EN
  assign last_round_key = key_q;
`endif

endmodule

// File: tb/tb_aes_encrypt_iter.sv
// Directed bench for aes_encrypt_iter using FIPS-197 vectors.
// Define AES_LAST_KEY_OUT_EN to also check the last_round_key port.
module tb_aes_encrypt_iter;

  localparam logic [127:0] KEY_A = 128'h000102030405060708090a0b0c0d0e0f;
  localparam logic [127:0] PT_A  = 128'h00112233445566778899aabbccddeeff;
  localparam logic [127:0] CT_A  = 128'h69c4e0d86a7b0430d8cdb78070b4c55a;
  localparam logic [127:0] KEY_B = 128'h2b7e151628aed2a6abf7158809cf4f3c;
  localparam logic [127:0] PT_B  = 128'h3243f6a8885a308d313198a2e0370734;
  localparam logic [127:0] CT_B  = 128'h3925841d02dc09fbdc118597196a0b32;
  localparam logic [127:0] LK_B  = 128'hd014f9a8c9ee2589e13f0cc8b6630ca6;

  logic         clk;
  logic         rst_n;
  logic         in_valid;
  logic         in_ready;
  logic [127:0] plaintext;
  logic [127:0] cipher_key;
  logic         out_valid;
  logic         out_ready;
  logic [127:0] ciphertext;
  logic         busy;
`ifdef AES_LAST_KEY_OUT_EN
  logic [127:0] last_round_key;
`endif

  int checks = 0;
  int errors = 0;

  aes_encrypt_iter dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .in_valid   (in_valid),
    .in_ready   (in_ready),
    .plaintext  (plaintext),
    .cipher_key (cipher_key),
    .out_valid  (out_valid),
    .out_ready  (out_ready),
    .ciphertext (ciphertext),
`ifdef AES_LAST_KEY_OUT_EN
    .last_round_key (last_round_key),
`endif
    .busy       (busy)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Presents a pair for exactly one accepting edge; DUT must be idle.
  task automatic accept_block(input logic [127:0] pt, input logic [127:0] key);
    plaintext  = pt;
    cipher_key = key;
    in_valid   = 1'b1;
    @(posedge clk); #1;
    in_valid   = 1'b0;
  endtask

  // Edges counted from and including the accepting edge until out_valid is seen.
  task automatic wait_done(output int edges);
    edges = 1;
    while (out_valid !== 1'b1 && edges < 40) begin
      @(posedge clk); #1;
      edges++;
    end
  endtask

  task automatic test_reset();
    rst_n = 1'b0;
    #12;
    checks++;
    if (in_ready !== 1'b1) begin errors++; $display("FAIL reset_in_ready got %b want 1", in_ready); end
    checks++;
    if (out_valid !== 1'b0) begin errors++; $display("FAIL reset_out_valid got %b want 0", out_valid); end
    checks++;
    if (busy !== 1'b0) begin errors++; $display("FAIL reset_busy got %b want 0", busy); end
    checks++;
    if (ciphertext !== 128'h0) begin errors++; $display("FAIL reset_ct got %h want 0", ciphertext); end
`ifdef AES_LAST_KEY_OUT_EN
    checks++;
    if (last_round_key !== 128'h0) begin errors++; $display("FAIL reset_lrk got %h want 0", last_round_key); end
`endif
    @(negedge clk) rst_n = 1'b1;
    @(posedge clk); #1;
  endtask

  task automatic test_vector_a();
    int n;
    out_ready = 1'b1;
    accept_block(PT_A, KEY_A);
    checks++;
    if (busy !== 1'b1 || in_ready !== 1'b0) begin
      errors++; $display("FAIL a_busy got busy=%b in_ready=%b want 1/0", busy, in_ready);
    end
    wait_done(n);
    checks++;
    if (n != 11) begin errors++; $display("FAIL a_latency got %0d want 11", n); end
    checks++;
    if (ciphertext !== CT_A) begin errors++; $display("FAIL a_ct got %h want %h", ciphertext, CT_A); end
    @(posedge clk); #1;
    checks++;
    if (out_valid !== 1'b0 || in_ready !== 1'b1) begin
      errors++; $display("FAIL a_release got out_valid=%b in_ready=%b want 0/1", out_valid, in_ready);
    end
  endtask

  task automatic test_backpressure();
    int n;
    out_ready = 1'b0;
    accept_block(PT_B, KEY_B);
    wait_done(n);
    checks++;
    if (n != 11) begin errors++; $display("FAIL b_latency got %0d want 11", n); end
    checks++;
    if (ciphertext !== CT_B) begin errors++; $display("FAIL b_ct got %h want %h", ciphertext, CT_B); end
`ifdef AES_LAST_KEY_OUT_EN
    checks++;
    if (last_round_key !== LK_B) begin errors++; $display("FAIL b_lrk got %h want %h", last_round_key, LK_B); end
`endif
    for (int k = 0; k < 20; k++) begin
      in_valid   = 1'b1;
      plaintext  = PT_A;
      cipher_key = KEY_A;
      @(posedge clk); #1;
      checks++;
      if (ciphertext !== CT_B || out_valid !== 1'b1) begin
        errors++; $display("FAIL hold_ct cycle %0d got %h ov=%b want %h ov=1", k, ciphertext, out_valid, CT_B);
      end
      checks++;
      if (in_ready !== 1'b0) begin errors++; $display("FAIL hold_in_ready cycle %0d got %b want 0", k, in_ready); end
    end
    in_valid  = 1'b0;
    out_ready = 1'b1;
    @(posedge clk); #1;
    checks++;
    if (out_valid !== 1'b0 || in_ready !== 1'b1 || busy !== 1'b0) begin
      errors++; $display("FAIL hold_release got ov=%b ir=%b busy=%b want 0/1/0", out_valid, in_ready, busy);
    end
  endtask

  task automatic test_input_change();
    int n;
    out_ready = 1'b0;
    accept_block(PT_A, KEY_A);
    plaintext  = PT_B;
    cipher_key = KEY_B;
    in_valid   = 1'b1;
    wait_done(n);
    checks++;
    if (n != 11) begin errors++; $display("FAIL chg_latency got %0d want 11", n); end
    checks++;
    if (ciphertext !== CT_A) begin errors++; $display("FAIL chg_ct got %h want %h", ciphertext, CT_A); end
    in_valid  = 1'b0;
    out_ready = 1'b1;
    @(posedge clk); #1;
    checks++;
    if (in_ready !== 1'b1) begin errors++; $display("FAIL chg_release got %b want 1", in_ready); end
  endtask

  task automatic test_back_to_back();
    int   acc_edge;
    logic rdy;
    acc_edge   = -1;
    out_ready  = 1'b1;
    plaintext  = PT_A;
    cipher_key = KEY_A;
    in_valid   = 1'b1;
    @(posedge clk); #1;
    plaintext  = PT_B;
    cipher_key = KEY_B;
    for (int k = 1; k <= 23; k++) begin
      rdy = in_ready;
      @(posedge clk); #1;
      if (rdy && acc_edge < 0) acc_edge = k;
      if (k == 10) begin
        checks++;
        if (out_valid !== 1'b1 || ciphertext !== CT_A) begin
          errors++; $display("FAIL b2b_first got ov=%b ct=%h want 1 %h", out_valid, ciphertext, CT_A);
        end
      end
      if (k == 22) begin
        checks++;
        if (out_valid !== 1'b1 || ciphertext !== CT_B) begin
          errors++; $display("FAIL b2b_second got ov=%b ct=%h want 1 %h", out_valid, ciphertext, CT_B);
        end
      end
    end
    in_valid = 1'b0;
    checks++;
    if (acc_edge != 12) begin errors++; $display("FAIL b2b_accept_edge got %0d want 12", acc_edge); end
    @(posedge clk); #1;
  endtask

  task automatic test_midround_reset();
    int n;
    out_ready = 1'b0;
    accept_block(PT_A, KEY_A);
    repeat (4) @(posedge clk);
    #3;
    rst_n = 1'b0;
    #1;
    checks++;
    if (in_ready !== 1'b1 || out_valid !== 1'b0 || busy !== 1'b0) begin
      errors++; $display("FAIL mid_reset_ctl got ir=%b ov=%b busy=%b want 1/0/0", in_ready, out_valid, busy);
    end
    checks++;
    if (ciphertext !== 128'h0) begin errors++; $display("FAIL mid_reset_ct got %h want 0", ciphertext); end
`ifdef AES_LAST_KEY_OUT_EN
    checks++;
    if (last_round_key !== 128'h0) begin errors++; $display("FAIL mid_reset_lrk got %h want 0", last_round_key); end
`endif
    repeat (3) @(posedge clk);
    #1;
    checks++;
    if (out_valid !== 1'b0) begin errors++; $display("FAIL mid_reset_hold got %b want 0", out_valid); end
    @(negedge clk) rst_n = 1'b1;
    @(posedge clk); #1;
    out_ready = 1'b1;
    accept_block(PT_A, KEY_A);
    wait_done(n);
    checks++;
    if (n != 11) begin errors++; $display("FAIL post_reset_latency got %0d want 11", n); end
    checks++;
    if (ciphertext !== CT_A) begin errors++; $display("FAIL post_reset_ct got %h want %h", ciphertext, CT_A); end
    @(posedge clk); #1;
  endtask

  initial begin
    rst_n      = 1'b0;
    in_valid   = 1'b0;
    out_ready  = 1'b0;
    plaintext  = '0;
    cipher_key = '0;
    test_reset();
    test_vector_a();
    test_backpressure();
    test_input_change();
    test_back_to_back();
    test_midround_reset();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

  initial begin
    #100000;
    $display("FAIL watchdog timeout");
    $fatal(1, "timeout");
  end

endmodule

// File: doc/aes_encrypt_iter.md
AES_ENCRYPT_ITER -- requirements
Module: aes_encrypt_iter

Interface
REQ-001 Parameters: none.
REQ-002 clk  input  1  single clock; all state updates on posedge clk.
REQ-003 rst_n  input  1  reset, asynchronous assert, active-low.
REQ-004 in_valid  input  1  plaintext/key pair offered.
REQ-005 in_ready  output  1  block idle and able to accept a pair.
REQ-006 plaintext  input  128  AES-128 plaintext; bits [127:120] are byte 0 (FIPS-197 order).
REQ-007 cipher_key  input  128  AES-128 cipher key; same byte order.
REQ-008 out_valid  output  1  ciphertext valid.
REQ-009 out_ready  input  1  consumer accepts ciphertext.
REQ-010 ciphertext  output  128  AES-128 ciphertext; same byte order.
REQ-011 busy  output  1  high in any state other than IDLE.

Function
REQ-012 The block SHALL be an iterative AES-128 encryptor (inverse direction of the existing decrypt round), one round per clock, with on-the-fly key expansion.
REQ-013 FSM states SHALL be IDLE, ROUND, DONE; in_ready = (state==IDLE); out_valid = (state==DONE).
REQ-014 IDLE->ROUND on in_valid&in_ready: state_reg <= plaintext ^ cipher_key, key_reg <= cipher_key, round_cnt <= 1.
REQ-015 In ROUND, each cycle SHALL compute next round key from key_reg with rcon[round_cnt] (01,02,04,08,10,20,40,80,1b,36) and state_reg <= round(state_reg, next key); key_reg <= next key; round_cnt increments.
REQ-016 Rounds 1-9 SHALL apply SubBytes, ShiftRows, MixColumns, AddRoundKey; round 10 SHALL omit MixColumns.
REQ-017 After round 10 the FSM SHALL go ROUND->DONE; latency from accepting edge to out_valid high SHALL be exactly 11 cycles.
REQ-018 In DONE, ciphertext SHALL hold stable until out_valid&out_ready, then DONE->IDLE; back-pressure of any length SHALL be tolerated.
REQ-019 in_valid during ROUND or DONE SHALL be ignored (in_ready low); plaintext/cipher_key are sampled only on the accepting edge.
REQ-020 Maximum throughput SHALL be one block per 12 cycles (accept, 10 rounds, DONE handshake with out_ready held high).
REQ-021 round_cnt SHALL be 4 bits; values 11-15 are unreachable; never wraps.
REQ-022 ciphertext SHALL be driven directly from state_reg; its value outside DONE is don't-care.

Reset
REQ-023 rst_n low SHALL immediately force state=IDLE, round_cnt=0, state_reg=0, key_reg=0; outputs in_ready=1, out_valid=0, busy=0, ciphertext=0.
REQ-024 Reset mid-ROUND or in DONE SHALL abort the block with no output; first accept after rst_n deasserts behaves as from power-up.

Configuration
REQ-025 Macro AES_LAST_KEY_OUT_EN: when defined, output last_round_key [127:0] SHALL carry key_reg (round-10 key) valid whenever out_valid is high, for seeding the decrypt key schedule; reset value 0.
REQ-026 Without AES_LAST_KEY_OUT_EN the port SHALL not exist and no behaviour changes.

Structure
REQ-027 Shared package SHALL hold: FSM state enum, rcon table constant, AES_NR=10 constant, 128-bit block typedef.
REQ-028 One sub-module encrypt_round (combinational: SubBytes, ShiftRows, optional MixColumns by a final flag, AddRoundKey) SHALL be instantiated once; key expansion step SHALL live in the top.

Verification
REQ-029 key 000102030405060708090a0b0c0d0e0f, pt 00112233445566778899aabbccddeeff -> ct 69c4e0d86a7b0430d8cdb78070b4c55a, out_valid exactly 11 cycles after accept.
REQ-030 key 2b7e151628aed2a6abf7158809cf4f3c, pt 3243f6a8885a308d313198a2e0370734 -> ct 3925841d02dc09fbdc118597196a0b32; with AES_LAST_KEY_OUT_EN last_round_key = d014f9a8c9ee2589e13f0cc8b6630ca6.
REQ-031 out_ready low 20 cycles in DONE -> ciphertext stable, in_ready low, new in_valid ignored; release -> IDLE next cycle.
REQ-032 Back-to-back vectors with in_valid and out_ready held high -> accepts every 12 cycles, both ciphertexts correct.
REQ-033 rst_n pulsed low at round 5 -> outputs at reset values same cycle, no out_valid; next vector from REQ-029 yields correct ct.
REQ-034 Plaintext/key changed during ROUND -> ciphertext unaffected.
